handshake_pipe_slice: RTL
=========================

# handshake_pipe_slice

Parametrised valid/ready register slice: a chain of `STAGES` identical pipeline stages between a master and a slave handshake interface. Each stage is one of three modes: forward-registered, ready-registered (skid), or fully registered. It replaces the fixed 32-bit single-stage ready-patting block and is used wherever long handshake paths need timing breaks in valid/data, ready, or both.

## Interface
- `DATA_W`, 32, payload width in bits (≥1)
- `STAGES`, 1, number of cascaded stages (≥1; 0 is an elaboration error)
- `MODE`, 2, per-stage mode: 0 = FWD (valid/data registered), 1 = BWD (ready registered, skid), 2 = FULL (both registered); other values are an elaboration error

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `master_valid`  in  1  upstream beat valid
- `master_data`  in  DATA_W  upstream payload
- `master_ready`  out  1  slice accepts beat this cycle
- `slave_valid`  out  1  downstream beat valid
- `slave_data`  out  DATA_W  downstream payload
- `slave_ready`  in  1  downstream accepts beat
- `occupancy`  out  $clog2(2*STAGES+1)  beats held (only with `HS_SLICE_OCC_EN`)

## Operation
- Transfer occurs on a port when valid && ready at a rising edge; no beat is lost, duplicated or reordered.
- Valid is never retracted and data is held stable while valid && !ready on `slave_*`. The upstream side must obey the same rule.
- FWD stage (capacity 1): registers `v_q`/`d_q`. ready_in = !v_q || ready_out (combinational path). Load when valid_in && ready_in. Clear v_q when ready_out && !valid_in.
- BWD stage (capacity 1): skid registers `sv_q`/`sd_q`. valid_out = sv_q || valid_in. data_out = sv_q ? sd_q : data_in. ready_in = !sv_q (registered). Set sv_q and capture data_in when valid_in && !ready_out && !sv_q. Clear sv_q when ready_out.
- FULL stage (capacity 2): output regs `ov_q`/`od_q` plus skid regs `sv_q`/`sd_q`. ready_in = !sv_q. valid_out = ov_q, both registered.
  - Accepted beat goes to the output reg if it is empty or draining this cycle and skid is empty; otherwise it goes to skid.
  - When the output drains and skid is full, skid moves to output and skid empties.
- Stage k's output feeds stage k+1's input. Stage 0 connects to `master_*`, stage STAGES-1 to `slave_*`.

## Timing
- Reset (async assert, sync-safe deassert): all valid regs 0, all data regs 0. Immediately: `slave_valid`=0, `master_ready`=1, `occupancy`=0. `slave_data` = 0 for MODE 0/2, and follows `master_data` (combinational) for MODE 1.
- Reset asserted mid-transfer discards all held beats. No partial state survives.
- Latency, empty chain, `slave_ready`=1: MODE 0/2 = STAGES cycles; MODE 1 = 0 cycles (combinational pass-through).
- Throughput: 1 beat/cycle sustained in all modes while `slave_ready`=1.
- Backpressure: with `slave_ready` held 0 from an empty state and `master_valid`=1, exactly STAGES×capacity beats are accepted before `master_ready` drops. Capacity is 1 for MODE 0/1 and 2 for MODE 2.
- Simultaneous drain and fill in a full FWD stage is one beat in, one beat out, occupancy unchanged.
- `master_ready` is a pure register output for MODE 1/2. For MODE 0 it has a combinational path from `slave_ready`.

## Configuration
- `HS_SLICE_OCC_EN` defined: `occupancy` port exists. It is a registered counter, +1 on each master transfer and −1 on each slave transfer (net 0 when both happen), range 0..STAGES×capacity, reset 0. For MODE 1 it counts only beats held in skid registers, so pass-through beats contribute 0.
- Not defined: port and counter are absent. Datapath behaviour is identical.

## Test plan
- Reset: MODE 2, STAGES=3. Assert `rst` mid-stream → `slave_valid`=0, `master_ready`=1, `occupancy`=0 within the same cycle. First beat after release appears 3 cycles after acceptance.
- Streaming: each MODE, STAGES=2, `slave_ready`=1, send 0x1..0x40 back-to-back → 64 beats out in order, no bubbles. Latency is 2 cycles for MODE 0/2 and 0 for MODE 1.
- Fill: MODE 2, STAGES=2, `slave_ready`=0, `master_valid`=1 with incrementing data → exactly 4 accepted, then `master_ready`=0 and `occupancy`=4. Release → 0x1..0x4 out in order.
- Skid: MODE 1, STAGES=1. Beat 0xA5A5A5A5 offered while `slave_ready`=0 → captured. `master_ready`=0 next cycle. `slave_data` holds 0xA5A5A5A5 until `slave_ready`=1.
- Random: MODE 0..2, STAGES=1..4, random `master_valid`/`slave_ready` at 50% over 10k cycles → scoreboard matches. `slave_data` never changes while `slave_valid` && !`slave_ready`.
- Width: DATA_W=1 and DATA_W=128 → elaborate and pass the streaming test.

Source files
------------

// File: rtl/handshake_pipe_slice.sv
// ----------------------------------------------------------------------------
// handshake_pipe_slice
//
// Parametrised valid/ready register slice. A chain of STAGES identical stages
// sits between the master (upstream) and slave (downstream) handshake ports.
// Every stage uses the same MODE:
//   0 = FWD  : valid/data registered, ready combinational (capacity 1)
//   1 = BWD  : ready registered via a skid buffer, valid/data pass-through
//              (capacity 1)
//   2 = FULL : valid/data and ready all registered (capacity 2)
//
// Parameters:
//   DATA_W  payload width in bits (>= 1)
//   STAGES  number of cascaded stages (>= 1)
//   MODE    stage mode, 0/1/2 as above
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset, clears every held beat
//   master_valid  upstream beat valid
//   master_data   upstream payload
//   master_ready  slice accepts the upstream beat this cycle
//   slave_valid   downstream beat valid
//   slave_data    downstream payload
//   slave_ready   downstream accepts the beat
//   occupancy     number of beats held (only when HS_SLICE_OCC_EN is defined)
//
// Optional feature macro: HS_SLICE_OCC_EN adds the occupancy port and its
// counter. Without it the datapath is unchanged and the port is absent.
// ----------------------------------------------------------------------------
module handshake_pipe_slice #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned MODE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              master_valid,
  input  logic [DATA_W-1:0] master_data,
  output logic              master_ready,
  output logic              slave_valid,
  output logic [DATA_W-1:0] slave_data,
  input  logic              slave_ready
`ifdef HS_SLICE_OCC_EN
  ,
  output logic [$clog2(2*STAGES+1)-1:0] occupancy
`endif
);

  typedef enum int unsigned {
    STAGE_FWD  = 0,
    STAGE_BWD  = 1,
    STAGE_FULL = 2
  } stage_mode_e;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (DATA_W == 0) begin : g_bad_width
    $error("handshake_pipe_slice: DATA_W must be at least 1");
  end
  if (STAGES == 0) begin : g_bad_stages
    $error("handshake_pipe_slice: STAGES must be at least 1");
  end
  if (MODE > STAGE_FULL) begin : g_bad_mode
    $error("handshake_pipe_slice: MODE must be 0, 1 or 2");
  end

  // --------------------------------------------------------------------------
  // Stage chain. Each stage owns its own handshake nets so that the
  // combinational ready (FWD) or valid (BWD) ripple never forms a loop on a
  // shared vector; neighbours are reached by hierarchical reference.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              up_valid;
    logic [DATA_W-1:0] up_data;
    logic              up_ready;
    logic              dn_valid;
    logic [DATA_W-1:0] dn_data;
    logic              dn_ready;

    if (k == 0) begin : g_first
      assign up_valid = master_valid;
      assign up_data  = master_data;
    end else begin : g_link
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
    end

    if (k == STAGES - 1) begin : g_last
      assign dn_ready = slave_ready;
    end else begin : g_next
      assign dn_ready = g_stage[k+1].up_ready;
    end

    if (MODE == STAGE_FWD) begin : g_fwd
      logic              v_q;
      logic [DATA_W-1:0] d_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (up_valid && up_ready) begin
          v_q <= 1'b1;
          d_q <= up_data;
        end else if (dn_ready) begin
          v_q <= 1'b0;
        end
      end

      assign up_ready = !v_q || dn_ready;
      assign dn_valid = v_q;
      assign dn_data  = d_q;

    end else if (MODE == STAGE_BWD) begin : g_bwd
      logic              sv_q;
      logic [DATA_W-1:0] sd_q;

      // Capture only when the beat is offered, downstream stalls and the
      // skid is free; any downstream ready empties the skid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sv_q <= 1'b0;
          sd_q <= '0;
        end else if (dn_ready) begin
          sv_q <= 1'b0;
        end else if (up_valid && !sv_q) begin
          sv_q <= 1'b1;
          sd_q <= up_data;
        end
      end

      assign up_ready = !sv_q;
      // The pass-through valid is masked during reset so no beat appears
      // downstream while the slice is being cleared.
      assign dn_valid = !rst && (sv_q || up_valid);
      assign dn_data  = sv_q ? sd_q : up_data;

    end else begin : g_full
      logic              ov_q;
      logic [DATA_W-1:0] od_q;
      logic              sv_q;
      logic [DATA_W-1:0] sd_q;
      logic              accept;
      logic              out_free;

      assign accept   = up_valid && !sv_q;
      // Output register can take a new beat at this edge.
      assign out_free = !ov_q || dn_ready;

      // Skid is only ever occupied while the output register is full, so
      // when the output frees up the skid beat always has priority.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ov_q <= 1'b0;
          od_q <= '0;
          sv_q <= 1'b0;
          sd_q <= '0;
        end else if (out_free) begin
          if (sv_q) begin
            ov_q <= 1'b1;
            od_q <= sd_q;
            sv_q <= 1'b0;
          end else if (accept) begin
            ov_q <= 1'b1;
            od_q <= up_data;
          end else begin
            ov_q <= 1'b0;
          end
        end else if (accept) begin
          sv_q <= 1'b1;
          sd_q <= up_data;
        end
      end

      assign up_ready = !sv_q;
      assign dn_valid = ov_q;
      assign dn_data  = od_q;
    end
  end

  assign master_ready = g_stage[0].up_ready;
  assign slave_valid  = g_stage[STAGES-1].dn_valid;
  assign slave_data   = g_stage[STAGES-1].dn_data;

`ifdef HS_SLICE_OCC_EN
  // --------------------------------------------------------------------------
  // Occupancy: beats accepted at the master port and not yet delivered at the
  // slave port. A pass-through beat in BWD mode transfers on both ports in
  // the same cycle and therefore nets to zero.
  // --------------------------------------------------------------------------
  localparam int unsigned OCC_W = $clog2(2*STAGES+1);

  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;

  assign in_xfer  = master_valid && master_ready;
  assign out_xfer = slave_valid && slave_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign occupancy = occ_q;
`endif

endmodule
